// File: rtl/alu_exec_unit.sv
// ALU execution unit: handshaked operand intake, registered result, iterative or barrel shifter.
// Define ALU_BARREL_SHIFT_EN to build single-cycle shifts instead of the bit-serial shifter.

package alu_exec_pkg;

    typedef enum logic [3:0] {
        ADD  = 4'd0,
        SUB  = 4'd1,
        SLT  = 4'd2,
        SLTU = 4'd3,
        XOR  = 4'd4,
        OR   = 4'd5,
        AND  = 4'd6,
        SLL  = 4'd7,
        SRL  = 4'd8,
        SRA  = 4'd9,
        FWD  = 4'd10
    } operation_t;

    typedef enum logic {
        LOW  = 1'b0,
        HIGH = 1'b1
    } flag_t;

endpackage

module alu_exec_unit
    import alu_exec_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned SHAMT_W    = $clog2(DATA_WIDTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  operation_t            opSel,
    input  logic [DATA_WIDTH-1:0] bus_a,
    input  logic [DATA_WIDTH-1:0] bus_b,
    input  flag_t                 error_in,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] result,
    output logic                  zero,
    output flag_t                 error_out
);

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StShift = 2'd1;
    localparam logic [1:0] StDone  = 2'd2;

    logic [1:0]            state_q, state_d;
    logic [DATA_WIDTH-1:0] result_q, result_d;
    flag_t                 error_q, error_d;
    logic [SHAMT_W-1:0]    shamt;

    assign shamt = bus_b[SHAMT_W-1:0];

`ifndef ALU_BARREL_SHIFT_EN
    // Shift direction is latched because opSel is not held during SHIFT.
    operation_t            op_q, op_d;
    logic [SHAMT_W-1:0]    cnt_q, cnt_d;
`endif

    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        error_d  = error_q;
`ifndef ALU_BARREL_SHIFT_EN
        op_d     = op_q;
        cnt_d    = cnt_q;
`endif
        case (state_q)
            StIdle: begin
                if (in_valid) begin
                    state_d = StDone;
                    error_d = LOW;
`ifndef ALU_BARREL_SHIFT_EN
                    op_d    = opSel;
`endif
                    if (error_in == HIGH) begin
                        result_d = '0;
                        error_d  = HIGH;
                    end else begin
                        case (opSel)
                            ADD:  result_d = bus_a + bus_b;
                            SUB:  result_d = bus_a - bus_b;
                            SLT:  result_d = {{(DATA_WIDTH-1){1'b0}},
                                              $signed(bus_a) < $signed(bus_b)};
                            SLTU: result_d = {{(DATA_WIDTH-1){1'b0}}, bus_a < bus_b};
                            XOR:  result_d = bus_a ^ bus_b;
                            OR:   result_d = bus_a | bus_b;
                            AND:  result_d = bus_a & bus_b;
                            FWD:  result_d = bus_a;
`ifdef ALU_BARREL_SHIFT_EN
                            SLL:  result_d = bus_a << shamt;
                            SRL:  result_d = bus_a >> shamt;
                            SRA:  result_d = $signed(bus_a) >>> shamt;
`else
                            SLL, SRL, SRA: begin
                                result_d = bus_a;
                                if (shamt != '0) begin
                                    cnt_d   = shamt;
                                    state_d = StShift;
                                end
                            end
`endif
                            default: begin
                                result_d = '0;
                                error_d  = HIGH;
                            end
                        endcase
                    end
                end
            end
`ifndef ALU_BARREL_SHIFT_EN
            StShift: begin
                case (op_q)
                    SLL:     result_d = {result_q[DATA_WIDTH-2:0], 1'b0};
                    SRL:     result_d = {1'b0, result_q[DATA_WIDTH-1:1]};
                    default: result_d = {result_q[DATA_WIDTH-1], result_q[DATA_WIDTH-1:1]};
                endcase
                cnt_d = cnt_q - SHAMT_W'(1);
                if (cnt_q == SHAMT_W'(1)) begin
                    state_d = StDone;
                end
            end
`endif
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            result_q <= '0;
            error_q  <= LOW;
`ifndef ALU_BARREL_SHIFT_EN
            op_q     <= ADD;
            cnt_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            error_q  <= error_d;
`ifndef ALU_BARREL_SHIFT_EN
            op_q     <= op_d;
            cnt_q    <= cnt_d;
`endif
        end
    end

    assign in_ready  = (state_q == StIdle);
    assign out_valid = (state_q == StDone);
    assign result    = result_q;
    assign zero      = (result_q == '0);
    assign error_out = error_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed self-checking bench for alu_exec_unit; expected latencies follow ALU_BARREL_SHIFT_EN.

module tb_alu_exec_unit;
    import alu_exec_pkg::*;

`ifdef ALU_BARREL_SHIFT_EN
    localparam int unsigned IterShift = 0;
`else
    localparam int unsigned IterShift = 1;
`endif

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    operation_t  op_sel;
    logic [31:0] bus_a;
    logic [31:0] bus_b;
    flag_t       err_in;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        zero;
    flag_t       err_out;

    int checks   = 0;
    int failures = 0;

    alu_exec_unit #(
        .DATA_WIDTH(32)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .opSel     (op_sel),
        .bus_a     (bus_a),
        .bus_b     (bus_b),
        .error_in  (err_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero),
        .error_out (err_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic send(input string tag, input operation_t op, input logic [31:0] a,
                        input logic [31:0] b, input flag_t e);
        check({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
        in_valid = 1'b1;
        op_sel   = op;
        bus_a    = a;
        bus_b    = b;
        err_in   = e;
        tick();
        in_valid = 1'b0;
    endtask

    // Counts cycles after the accept edge until out_valid, bounded.
    task automatic wait_done(output int lat);
        lat = 0;
        while (out_valid !== 1'b1 && lat < 64) begin
            tick();
            lat++;
        end
    endtask

    task automatic run(input string tag, input operation_t op, input logic [31:0] a,
                       input logic [31:0] b, input flag_t e, input logic [31:0] exp_res,
                       input flag_t exp_err, input int exp_lat);
        int lat;
        send(tag, op, a, b, e);
        wait_done(lat);
        check({tag, "_latency"}, lat, exp_lat);
        check({tag, "_result"}, result, exp_res);
        check({tag, "_zero"}, {31'd0, zero}, {31'd0, exp_res == 32'd0});
        check({tag, "_error"}, {31'd0, err_out}, {31'd0, exp_err});
        tick();
        check({tag, "_consumed"}, {31'd0, out_valid}, 32'd0);
        check({tag, "_ready_again"}, {31'd0, in_ready}, 32'd1);
    endtask

    initial begin
        int lat;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        op_sel    = ADD;
        bus_a     = '0;
        bus_b     = '0;
        err_in    = LOW;
        tick();
        tick();
        rst = 1'b0;
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_result", result, 32'd0);
        check("rst_zero", {31'd0, zero}, 32'd1);
        check("rst_error", {31'd0, err_out}, 32'd0);

        out_ready = 1'b1;
        run("add_ovf", ADD, 32'h7FFF_FFFF, 32'd1, LOW, 32'h8000_0000, LOW, 0);
        run("sub_zero", SUB, 32'd5, 32'd5, LOW, 32'd0, LOW, 0);
        run("slt", SLT, 32'hFFFF_FFFF, 32'd1, LOW, 32'd1, LOW, 0);
        run("sltu", SLTU, 32'hFFFF_FFFF, 32'd1, LOW, 32'd0, LOW, 0);
        run("and", AND, 32'hF0F0_1234, 32'h0FF0_FF00, LOW, 32'h00F0_1200, LOW, 0);
        run("fwd", FWD, 32'hDEAD_BEEF, 32'h1111_1111, LOW, 32'hDEAD_BEEF, LOW, 0);
        run("sra4", SRA, 32'h8000_0000, 32'd4, LOW, 32'hF800_0000, LOW, 4 * IterShift);
        // Only bits [4:0] of bus_b form the shift amount, so 32 means no shift.
        run("sll0", SLL, 32'h1234_5678, 32'd32, LOW, 32'h1234_5678, LOW, 0);
        run("sll1", SLL, 32'h8000_0001, 32'd1, LOW, 32'h0000_0002, LOW, 1 * IterShift);
        run("srl31", SRL, 32'h8000_0000, 32'd31, LOW, 32'h0000_0001, LOW, 31 * IterShift);
        run("sra_pos", SRA, 32'h4000_0000, 32'd2, LOW, 32'h1000_0000, LOW, 2 * IterShift);

        // Backpressure: result held while out_ready is low; new requests are refused.
        out_ready = 1'b0;
        send("xor_bp", XOR, 32'hA5A5_A5A5, 32'hFFFF_0000, LOW);
        wait_done(lat);
        check("xor_bp_latency", lat, 0);
        in_valid = 1'b1;
        op_sel   = ADD;
        bus_a    = 32'd1;
        bus_b    = 32'd1;
        err_in   = LOW;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_result", result, 32'h5A5A_A5A5);
            check("bp_valid", {31'd0, out_valid}, 32'd1);
            check("bp_in_ready", {31'd0, in_ready}, 32'd0);
        end
        out_ready = 1'b1;
        tick();
        check("bp_released", {31'd0, out_valid}, 32'd0);
        check("bp_ready_back", {31'd0, in_ready}, 32'd1);
        tick();
        in_valid = 1'b0;
        check("bp_next_valid", {31'd0, out_valid}, 32'd1);
        check("bp_next_result", result, 32'd2);
        tick();
        check("bp_next_consumed", {31'd0, in_ready}, 32'd1);

        run("err_add", ADD, 32'd3, 32'd4, HIGH, 32'd0, HIGH, 0);
        run("ok_after_err", OR, 32'h0000_00F0, 32'h0000_000F, LOW, 32'h0000_00FF, LOW, 0);
        run("illegal_op", operation_t'(4'hF), 32'd3, 32'd4, LOW, 32'd0, HIGH, 0);

        // Reset mid-shift discards the pending operation.
        send("srl_rst", SRL, 32'hFFFF_FFFF, 32'd31, LOW);
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_valid", {31'd0, out_valid}, 32'd0);
        check("midrst_in_ready", {31'd0, in_ready}, 32'd1);
        check("midrst_result", result, 32'd0);
        check("midrst_zero", {31'd0, zero}, 32'd1);
        run("or_after_rst", OR, 32'h1200_0000, 32'h0034_0056, LOW, 32'h1234_0056, LOW, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_exec_unit.md
# alu_exec_unit

Execution-side consumer of the `operation_t` select produced by the ALU op decoder. It accepts one operation with its two operands over a valid/ready handshake, computes the result, and holds that result on a valid/ready output handshake until it is taken. Shifts run iteratively, one bit per cycle, so shift latency depends on the shift amount. It sits between the register-read/operand-mux stage and the writeback/branch logic of the datapath.

## Interface
- `DATA_WIDTH`, 32, operand and result width. Must be a power of two, ≥ 8.
- `SHAMT_W`, `$clog2(DATA_WIDTH)`, shift-amount width taken from `bus_b`.

- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  request valid.
- `in_ready`  out  1  unit can accept a request.
- `opSel`  in  `operation_t`  operation: ADD, SUB, SLT, SLTU, XOR, OR, AND, SLL, SRL, SRA, FWD.
- `bus_a`  in  DATA_WIDTH  operand 1.
- `bus_b`  in  DATA_WIDTH  operand 2. Bits `[SHAMT_W-1:0]` are the shift amount.
- `error_in`  in  `flag_t`  decoder error flag for this request.
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  consumer takes the result.
- `result`  out  DATA_WIDTH  computed value.
- `zero`  out  1  `result == 0`.
- `error_out`  out  `flag_t`  error for the held result.

## Operation
- FSM has three states: IDLE, SHIFT and DONE.
- `in_ready` = (state == IDLE).
- `out_valid` = (state == DONE).
- **IDLE:** on `in_valid && in_ready`, capture the opcode, operands and error flag, then branch:
  - `error_in == HIGH`: `result` = 0, `error_out` = HIGH, go to DONE.
  - `opSel` is not a defined `operation_t` value: `result` = 0, `error_out` = HIGH, go to DONE.
  - Non-shift op: registered result, go to DONE. Results by op:
    - ADD / SUB: modulo 2^DATA_WIDTH, carry and overflow discarded.
    - SLT: signed compare, result 1 or 0.
    - SLTU: unsigned compare, result 1 or 0.
    - XOR / OR / AND: bitwise.
    - FWD: `result` = `bus_a`.
  - Shift with amount n = 0: `result` = `bus_a`, go to DONE.
  - Shift with amount n > 0: load the shift register with `bus_a` and the counter with n, go to SHIFT.
- **SHIFT:** every cycle, shift by one bit and decrement the counter.
  - SLL fills with 0.
  - SRL fills with 0.
  - SRA fills with the sign bit of the current value.
  - The edge on which the counter goes 1→0 performs the last shift and moves to DONE.
  - Inputs are ignored while in SHIFT.
- **DONE:** `result`, `zero` and `error_out` are held stable.
  - `out_ready` = 1: go to IDLE.
  - `out_ready` = 0: stay in DONE.
- `zero` is derived from the registered `result` in every state.

## Timing
- Reset values: state IDLE, `result` 0, `zero` 1, `error_out` LOW, `out_valid` 0, `in_ready` 1. The shift counter is reset to 0.
- Reset asserted in any state, including mid-SHIFT or DONE, aborts the operation. The next edge applies the reset values and the pending result is lost.
- Let accept edge = T.
  - Non-shift, error, or shift with n = 0: `out_valid` is high in the cycle after T.
  - Shift with n > 0: `out_valid` is high in the cycle after edge T+n.
- Result is consumed on an edge with `out_valid && out_ready`; IDLE is entered on that edge.
- `in_ready` rises one cycle after consumption. Peak throughput is one operation per 2 cycles; there is no accept-while-DONE overlap.
- `in_valid` while not ready is ignored. The requester must hold the request until `in_ready`.
- `out_ready` asserted outside DONE has no effect.

## Configuration
- `ALU_BARREL_SHIFT_EN` defined:
  - Shifts of any amount complete like non-shift ops (DONE the cycle after accept).
  - The SHIFT state and shift counter are not built.
- `ALU_BARREL_SHIFT_EN` not defined: iterative shifter as described above.
- All other behaviour, the interface, and reset values are identical in both builds.

## Test plan
- Reset release, then ADD with `bus_a`=0x7FFF_FFFF, `bus_b`=1 and `out_ready`=1 → `out_valid` the cycle after accept, `result`=0x8000_0000, `zero`=0, `error_out`=LOW; `in_ready` back to 1 one cycle later.
- SUB 5−5, then SLT with 0xFFFF_FFFF vs 1, then SLTU with the same operands → results 0 (`zero`=1), 1, 0.
- SRA with `bus_a`=0x8000_0000, `bus_b`=4:
  - Iterative build: `out_valid` appears 4 cycles later than for ADD; `result`=0xF800_0000.
  - Barrel build: appears one cycle after accept.
  - Also SLL with shamt 0 returns `bus_a` in one cycle.
- Backpressure: hold `out_ready`=0 for 5 cycles after an XOR completes → `result` stable, `in_ready`=0, and a new `in_valid` is not accepted; release → consumed, new request accepted one cycle later.
- Error paths: `error_in`=HIGH with ADD, then an illegal `opSel` encoding → `result`=0, `zero`=1, `error_out`=HIGH for each.
- Assert `rst` during SHIFT of SRL by 31 → next cycle state IDLE, `out_valid`=0, `result`=0; a following OR works normally.
